// File: rtl/positnormalize_sum_es3.sv
// Posit<32,3> normalize/round of a raw sum; 3-cycle latency, one operand per cycle.
// No backpressure: each stage carries its own valid bit and never stalls.
package posit_defines_es3;
  parameter int ES = 3;
  parameter int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 41;
endpackage

module positnormalize_sum_es3
  import posit_defines_es3::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] in,
  input  logic                                      start,
  output logic [31:0]                               result,
  output logic                                      done
);

  // stage 1 decode of the raw sum
  logic signed [8:0] scale_in;
  logic [5:0]        k_in;
  logic [ES-1:0]     e_in;
  logic              sat_hi_in;
  logic              sat_lo_in;

  assign scale_in  = in[39:31];
  assign k_in      = scale_in[8:ES];
  assign e_in      = scale_in[ES-1:0];
  assign sat_hi_in = (scale_in >= 9'sd240);
  assign sat_lo_in = (scale_in <= -9'sd240);

  logic        s1_vld, s1_sgn, s1_inf, s1_zero, s1_sat_hi, s1_sat_lo;
  logic [5:0]  s1_k;
  logic [2:0]  s1_e;
  logic [28:0] s1_frac;

  // stage 2: regime pattern produced by an arithmetic shift of a 2-bit seed
  logic [4:0]         shamt;
  logic signed [71:0] seed;
  logic [71:0]        shifted;

  assign shamt   = s1_k[5] ? ~s1_k[4:0] : s1_k[4:0];
  assign seed    = {(s1_k[5] ? 2'b01 : 2'b10), s1_e, s1_frac, 38'b0};
  assign shifted = seed >>> shamt;

  logic        s2_vld, s2_sgn, s2_inf, s2_zero, s2_sat_hi, s2_sat_lo;
  logic [30:0] s2_field;
  logic        s2_guard, s2_sticky;

  // stage 3: round to nearest even, saturate, clamp away from zero/NaR
  logic        inc;
  logic [31:0] rounded;
  logic [30:0] mag_next;

  assign inc     = s2_guard & (s2_field[0] | s2_sticky);
  assign rounded = {1'b0, s2_field} + {31'b0, inc};

  always_comb begin
    mag_next = rounded[30:0];
    if (s2_sat_hi)             mag_next = 31'h7FFF_FFFF;
    else if (s2_sat_lo)        mag_next = 31'h0000_0001;
    else if (rounded[31])      mag_next = 31'h7FFF_FFFF;
    else if (rounded == 32'd0) mag_next = 31'h0000_0001;
  end

  logic        s3_vld, s3_sgn, s3_inf, s3_zero;
  logic [30:0] s3_mag;
  logic [31:0] enc;

  always_comb begin
    enc = {1'b0, s3_mag};
    if (s3_inf)       enc = 32'h8000_0000;
    else if (s3_zero) enc = 32'h0000_0000;
    else if (s3_sgn)  enc = -{1'b0, s3_mag};
  end

  // valids and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      s1_vld <= (start === 1'b1);
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      done   <= s3_vld;
      if (s3_vld) result <= enc;
    end
  end

  // datapath registers need no reset: they are qualified by the valids
  always_ff @(posedge clk) begin
    s1_sgn    <= in[40];
    s1_k      <= k_in;
    s1_e      <= e_in;
    s1_frac   <= in[30:2];
    s1_inf    <= in[1];
    s1_zero   <= in[0];
    s1_sat_hi <= sat_hi_in;
    s1_sat_lo <= sat_lo_in;

    s2_sgn    <= s1_sgn;
    s2_inf    <= s1_inf;
    s2_zero   <= s1_zero;
    s2_sat_hi <= s1_sat_hi;
    s2_sat_lo <= s1_sat_lo;
    s2_field  <= shifted[71:41];
    s2_guard  <= shifted[40];
    s2_sticky <= |shifted[39:0];

    s3_sgn    <= s2_sgn;
    s3_inf    <= s2_inf;
    s3_zero   <= s2_zero;
    s3_mag    <= mag_next;
  end

endmodule

// File: tb/tb_positnormalize_sum_es3.sv
// Directed and streaming checks for positnormalize_sum_es3.
module tb_positnormalize_sum_es3;

  logic        clk = 1'b0;
  logic        reset;
  logic [40:0] in;
  logic        start;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;

  positnormalize_sum_es3 dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .start  (start),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] mk(input logic sgn, input int scale, input logic [28:0] frac,
                                     input logic inf, input logic zero);
    logic [8:0] s9;
    s9 = scale[8:0];
    return {sgn, s9, frac, inf, zero};
  endfunction

  // bit-by-bit construction of the posit, independent of the shift trick in the design
  function automatic logic [31:0] ref_posit(input logic sgn, input int scale, input logic [28:0] frac,
                                            input logic inf, input logic zero);
    logic [79:0] bits;
    logic [30:0] fld;
    logic [31:0] mag;
    logic        g, st;
    int          pos, k, ev;
    if (inf)  return 32'h8000_0000;
    if (zero) return 32'h0000_0000;
    if (scale >= 240)       mag = 32'h7FFF_FFFF;
    else if (scale <= -240) mag = 32'h0000_0001;
    else begin
      k    = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
      ev   = scale - 8 * k;
      bits = '0;
      pos  = 79;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin bits[pos] = 1'b1; pos--; end
        pos--;
      end else begin
        pos = pos - (-k);
        bits[pos] = 1'b1;
        pos--;
      end
      for (int i = 2; i >= 0; i--) begin bits[pos] = ev[i]; pos--; end
      for (int i = 28; i >= 0; i--) begin bits[pos] = frac[i]; pos--; end
      fld = bits[79:49];
      g   = bits[48];
      st  = |bits[47:0];
      mag = {1'b0, fld} + {31'b0, (g & (fld[0] | st))};
      if (mag > 32'h7FFF_FFFF) mag = 32'h7FFF_FFFF;
      if (mag == 32'h0)        mag = 32'h0000_0001;
    end
    return sgn ? -mag : mag;
  endfunction

  // drive one operand and report the edge count at which done appeared (-1 if never)
  task automatic apply_one(input logic [40:0] v, output int lat, output logic [31:0] res);
    in    = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    res   = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && lat < 0) begin
        lat = c;
        res = result;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    in    = mk(1'b0, 0, 29'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || result !== 32'h0) begin
        bad++;
        $display("FAIL reset_state: done=%b result=%h, want done=0 result=00000000", done, result);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL start_during_reset: done=%b at cycle %0d, want 0", done, c);
      end
    end
  endtask

  task automatic test_basic();
    logic [40:0] vin[6];
    logic [31:0] vexp[6];
    int          lat;
    logic [31:0] res;
    vin[0] = mk(1'b0,  0, 29'h0, 1'b0, 1'b0); vexp[0] = 32'h4000_0000;
    vin[1] = mk(1'b0,  1, 29'h0, 1'b0, 1'b0); vexp[1] = 32'h4400_0000;
    vin[2] = mk(1'b0,  8, 29'h0, 1'b0, 1'b0); vexp[2] = 32'h6000_0000;
    vin[3] = mk(1'b0, -8, 29'h0, 1'b0, 1'b0); vexp[3] = 32'h2000_0000;
    vin[4] = mk(1'b1,  0, 29'h0, 1'b0, 1'b0); vexp[4] = 32'hC000_0000;
    vin[5] = mk(1'b0, -1, 29'h0, 1'b0, 1'b0); vexp[5] = 32'h3C00_0000;
    for (int i = 0; i < 6; i++) begin
      apply_one(vin[i], lat, res);
      total++;
      if (lat != 3) begin
        bad++;
        $display("FAIL basic_latency[%0d]: done after %0d edges, want 3", i, lat);
      end
      total++;
      if (res !== vexp[i]) begin
        bad++;
        $display("FAIL basic_result[%0d]: got %h want %h", i, res, vexp[i]);
      end
    end
    total++;
    if (result !== vexp[5]) begin
      bad++;
      $display("FAIL result_hold: got %h want %h", result, vexp[5]);
    end
  endtask

  task automatic test_rounding();
    logic [28:0] fr[3];
    logic [31:0] vexp[3];
    int          lat;
    logic [31:0] res;
    fr[0] = 29'h4; vexp[0] = 32'h4000_0000;
    fr[1] = 29'hC; vexp[1] = 32'h4000_0002;
    fr[2] = 29'h5; vexp[2] = 32'h4000_0001;
    for (int i = 0; i < 3; i++) begin
      apply_one(mk(1'b0, 0, fr[i], 1'b0, 1'b0), lat, res);
      total++;
      if (lat != 3 || res !== vexp[i]) begin
        bad++;
        $display("FAIL rounding[%0d]: got %h after %0d edges, want %h after 3", i, res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [40:0] vin[4];
    logic [31:0] vexp[4];
    int          lat;
    logic [31:0] res;
    vin[0] = mk(1'b0,  250, 29'h0,         1'b0, 1'b0); vexp[0] = 32'h7FFF_FFFF;
    vin[1] = mk(1'b0, -250, 29'h0,         1'b0, 1'b0); vexp[1] = 32'h0000_0001;
    vin[2] = mk(1'b1, -250, 29'h0,         1'b0, 1'b0); vexp[2] = 32'hFFFF_FFFF;
    vin[3] = mk(1'b0,  239, 29'h1FFF_FFFF, 1'b0, 1'b0); vexp[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      apply_one(vin[i], lat, res);
      total++;
      if (lat != 3 || res !== vexp[i]) begin
        bad++;
        $display("FAIL saturation[%0d]: got %h after %0d edges, want %h after 3", i, res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [40:0] vin[3];
    logic [31:0] vexp[3];
    int          lat;
    logic [31:0] res;
    vin[0] = mk(1'b0, 17,  29'h123, 1'b1, 1'b1); vexp[0] = 32'h8000_0000;
    vin[1] = mk(1'b1, -40, 29'h7,   1'b0, 1'b1); vexp[1] = 32'h0000_0000;
    vin[2] = mk(1'b1, 5,   29'h55,  1'b1, 1'b0); vexp[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      apply_one(vin[i], lat, res);
      total++;
      if (lat != 3 || res !== vexp[i]) begin
        bad++;
        $display("FAIL specials[%0d]: got %h after %0d edges, want %h after 3", i, res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] vin[8];
    logic [31:0] vexp[8];
    int          n_out;
    int          sc;
    logic        sg;
    logic [28:0] fr;
    for (int i = 0; i < 8; i++) begin
      sc      = int'($urandom_range(478)) - 239;
      sg      = 1'($urandom_range(1));
      fr      = 29'($urandom);
      vin[i]  = mk(sg, sc, fr, 1'b0, 1'b0);
      vexp[i] = ref_posit(sg, sc, fr, 1'b0, 1'b0);
    end
    n_out = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        in    = vin[c];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      total++;
      if (done !== (c >= 3 && c < 11)) begin
        bad++;
        $display("FAIL stream_done: done=%b at cycle %0d, want %b", done, c, (c >= 3 && c < 11));
      end
      if (done === 1'b1 && n_out < 8) begin
        total++;
        if (result !== vexp[n_out]) begin
          bad++;
          $display("FAIL stream_result[%0d]: got %h want %h", n_out, result, vexp[n_out]);
        end
        n_out++;
      end
    end
  endtask

  task automatic test_reset_mid();
    in    = mk(1'b0, 8, 29'h0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        total++;
        if (result !== 32'h0) begin
          bad++;
          $display("FAIL reset_clears_result: got %h want 00000000", result);
        end
        reset = 1'b0;
      end
      total++;
      if (done !== (c == 8)) begin
        bad++;
        $display("FAIL reset_mid_done: done=%b at cycle %0d, want %b", done, c, (c == 8));
      end
      if (c == 8) begin
        total++;
        if (result !== 32'h4000_0000) begin
          bad++;
          $display("FAIL reset_mid_result: got %h want 40000000", result);
        end
      end
      if (c == 4) begin
        in    = mk(1'b0, 0, 29'h0, 1'b0, 1'b0);
        start = 1'b1;
      end
      if (c == 5) start = 1'b0;
    end
  endtask

  task automatic test_x_start();
    in    = mk(1'b0, 0, 29'h0, 1'b0, 1'b0);
    start = 1'bx;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL x_start: done=%b at cycle %0d, want 0", done, c);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in    = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_specials();
    test_back_to_back();
    test_reset_mid();
    test_x_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/positnormalize_sum_es3.md
POSITNORMALIZE_SUM_ES3 -- requirements
Module: positnormalize_sum_es3

Interface
REQ-001 The block SHALL use these parameters: none; all widths come from package posit_defines_es3 (ES = 3, POSIT_SERIALIZED_WIDTH_SUM_ES3 = 41), and the output posit width is fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in  input  41  raw sum: [40] sgn, [39:31] scale (signed), [30:2] fraction (29 b, hidden bit already removed, MSB-aligned), [1] inf, [0] zero.
REQ-005 start  input  1  in is valid this cycle.
REQ-006 result  output  32  encoded posit<32,3>.
REQ-007 done  output  1  result is valid this cycle.

Function
REQ-008 Latency SHALL be exactly 3 cycles: start sampled high at edge N gives done=1 with the matching result after edge N+3.
REQ-009 Throughput SHALL be one operand per cycle with no stall and no backpressure; each stage carries its own valid bit.
REQ-010 Stage 1 SHALL register in/start and compute k = scale>>>3 (arithmetic), e = scale[2:0], sat_hi = (scale >= 240), sat_lo = (scale <= -240).
REQ-011 Stage 2 SHALL build the 31-bit magnitude field: regime (k>=0: k+1 ones then a zero; k<0: -k zeros then a one), then e, then fraction, truncated to 31 bits, with guard = first dropped bit and sticky = OR of all remaining dropped bits.
REQ-012 Stage 3 SHALL round to nearest, ties to even: increment when guard & (lsb | sticky).
REQ-013 Rounded magnitude SHALL be clamped to [0x00000001, 0x7FFFFFFF]; a nonzero input never encodes to zero or NaR.
REQ-014 sat_hi SHALL force magnitude 0x7FFFFFFF; sat_lo SHALL force 0x00000001; this precedes rounding.
REQ-015 sgn=1 SHALL output the 32-bit two's complement of {1'b0, magnitude}.
REQ-016 Specials SHALL have priority inf > zero > normal: inf -> 0x80000000; zero (inf=0) -> 0x00000000; sgn, scale and fraction are ignored.
REQ-017 When done=0, result SHALL hold its last value; it is don't-care to consumers.
REQ-018 An X on start SHALL be treated as 0.
REQ-019 Back-to-back starts SHALL produce back-to-back dones in order with no bubbles.

Reset
REQ-020 While reset=1 at an edge, all stage valids, done and result SHALL be cleared to 0.
REQ-021 A reset mid-operation SHALL discard every in-flight operand; done SHALL be 0 from the first edge with reset=1 until 3 edges after the first post-reset start.
REQ-022 A start held high during reset SHALL be ignored; there is no recovery or replay.

Verification
REQ-023 scale=0, frac=0, sgn=0 -> 0x40000000; scale=1 -> 0x44000000; scale=8 -> 0x60000000; scale=-8 -> 0x20000000; sgn=1, scale=0 -> 0xC0000000; each done exactly 3 cycles after start.
REQ-024 scale=0 with frac=29'h4 -> 0x40000000 (tie, even); frac=29'hC -> 0x40000002 (tie, odd rounds up); frac=29'h5 -> 0x40000001 (sticky).
REQ-025 Saturation: scale=250 -> 0x7FFFFFFF; scale=-250 -> 0x00000001; sgn=1, scale=-250 -> 0xFFFFFFFF; scale=239, frac all ones -> 0x7FFFFFFF (no wrap).
REQ-026 Specials: inf=1, zero=1 -> 0x80000000; zero=1 only -> 0x00000000; inf=1, sgn=1 -> 0x80000000.
REQ-027 Streaming: 8 consecutive starts with random legal inputs -> 8 consecutive dones, in order, each matching a reference model.
REQ-028 Reset: start at cycle 0, reset at cycle 1 -> done stays 0; a new start at cycle 5 -> done at cycle 8 only.
